// File: rtl/control_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, ir field positions, states.
// The MULDIV_EN build option enables the mul/div instruction class.
package control_pkg;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 27;
   localparam int unsigned RA_MSB  = 26;
   localparam int unsigned RA_LSB  = 23;
   localparam int unsigned RB_MSB  = 22;
   localparam int unsigned RB_LSB  = 19;
   localparam int unsigned RC_MSB  = 18;
   localparam int unsigned RC_LSB  = 15;

   localparam logic [4:0] OP_LD   = 5'h00;
   localparam logic [4:0] OP_ST   = 5'h02;
   localparam logic [4:0] OP_ADD  = 5'h03;
   localparam logic [4:0] OP_SUB  = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_OR   = 5'h06;
   localparam logic [4:0] OP_ADDI = 5'h0C;
   localparam logic [4:0] OP_MUL  = 5'h0F;
   localparam logic [4:0] OP_DIV  = 5'h10;
   localparam logic [4:0] OP_MFHI = 5'h17;
   localparam logic [4:0] OP_MFLO = 5'h18;
   localparam logic [4:0] OP_NOP  = 5'h1A;
   localparam logic [4:0] OP_HALT = 5'h1B;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_MUL = 4'd4;
   localparam logic [3:0] ALU_DIV = 4'd5;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP, CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST, CLS_MFHI, CLS_MFLO, CLS_HALT, CLS_MULDIV
   } cls_t;

   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      onehot16 = 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode to instruction-class mapping and 4-to-16 register index decode.
// mul/div are recognised only when MULDIV_EN is defined; otherwise they decode as nop.
module ctrl_decoder
   import control_pkg::*;
(
   input  logic [4:0]  opcode,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  rc,
   output cls_t        inst_class,
   output logic [3:0]  alu_sel,
   output logic [15:0] ra_oh,
   output logic [15:0] rb_oh,
   output logic [15:0] rc_oh
);

   always_comb begin
      inst_class = CLS_NOP;
      alu_sel    = ALU_ADD;
      case (opcode)
         OP_LD:   inst_class = CLS_LD;
         OP_ST:   inst_class = CLS_ST;
         OP_ADD:  inst_class = CLS_ALU;
         OP_SUB:  begin inst_class = CLS_ALU; alu_sel = ALU_SUB; end
         OP_AND:  begin inst_class = CLS_ALU; alu_sel = ALU_AND; end
         OP_OR:   begin inst_class = CLS_ALU; alu_sel = ALU_OR;  end
         OP_ADDI: inst_class = CLS_ADDI;
`ifdef MULDIV_EN
         OP_MUL:  begin inst_class = CLS_MULDIV; alu_sel = ALU_MUL; end
         OP_DIV:  begin inst_class = CLS_MULDIV; alu_sel = ALU_DIV; end
`endif
         OP_MFHI: inst_class = CLS_MFHI;
         OP_MFLO: inst_class = CLS_MFLO;
         OP_HALT: inst_class = CLS_HALT;
         default: inst_class = CLS_NOP;
      endcase
   end

   assign ra_oh = onehot16(ra);
   assign rb_oh = onehot16(rb);
   assign rc_oh = onehot16(rc);

endmodule

// File: rtl/control_unit.sv
// Moore-style control sequencer: fetch T0-T3, per-class execute steps, stop/halt handling.
// Build option MULDIV_EN adds the mul/div sequence driving lo_in/hi_in.
module control_unit
   import control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic        stop,
   output logic [15:0] gpr_in,
   output logic [15:0] gpr_out,
   output logic        hi_in,
   output logic        lo_in,
   output logic        pc_in,
   output logic        ir_in,
   output logic        z_in,
   output logic        y_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        hi_out,
   output logic        lo_out,
   output logic        pc_out,
   output logic        z_high_out,
   output logic        z_low_out,
   output logic        mdr_out,
   output logic        inport_out,
   output logic        c_out,
   output logic        read,
   output logic        write,
   output logic [3:0]  alu_op,
   output logic        inc_pc,
   output logic        run
);

   state_t      state, next_state, boundary;
   cls_t        inst_class;
   logic [3:0]  alu_sel;
   logic [15:0] ra_oh, rb_oh, rc_oh;
   logic        unused_ir_low;

   assign unused_ir_low = ^ir[RC_LSB-1:0];

   ctrl_decoder u_dec (
      .opcode     (ir[OPC_MSB:OPC_LSB]),
      .ra         (ir[RA_MSB:RA_LSB]),
      .rb         (ir[RB_MSB:RB_LSB]),
      .rc         (ir[RC_MSB:RC_LSB]),
      .inst_class (inst_class),
      .alu_sel    (alu_sel),
      .ra_oh      (ra_oh),
      .rb_oh      (rb_oh),
      .rc_oh      (rc_oh)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_RESET;
      else       state <= next_state;
   end

   // stop only matters on the last step of an instruction
   assign boundary = stop ? S_HALTED : S_T0;

   always_comb begin
      next_state = state;
      case (state)
         S_RESET:  next_state = S_T0;
         S_T0:     next_state = S_T1;
         S_T1:     next_state = S_T2;
         S_T2:     next_state = S_T3;
         S_T3:     next_state = S_T4;
         S_T4: begin
            case (inst_class)
               CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST, CLS_MULDIV: next_state = S_T5;
               CLS_HALT: next_state = S_HALTED;
               default:  next_state = boundary;
            endcase
         end
         S_T5:     next_state = S_T6;
         S_T6:     next_state = (inst_class == CLS_LD || inst_class == CLS_ST ||
                                 inst_class == CLS_MULDIV) ? S_T7 : boundary;
         S_T7:     next_state = (inst_class == CLS_MULDIV) ? boundary : S_T8;
         S_T8:     next_state = (inst_class == CLS_LD) ? S_T9 : boundary;
         S_T9:     next_state = boundary;
         S_HALTED: next_state = S_HALTED;
         default:  next_state = S_RESET;
      endcase
   end

   // Outputs decode the current state plus the datapath's ir, which only becomes
   // valid during T4; registering them would need ir a cycle earlier than it exists.
   always_comb begin
      gpr_in = '0;  gpr_out = '0;
      hi_in = 1'b0; lo_in = 1'b0; pc_in = 1'b0; ir_in = 1'b0;
      z_in = 1'b0;  y_in = 1'b0;  mar_in = 1'b0; mdr_in = 1'b0;
      hi_out = 1'b0; lo_out = 1'b0; pc_out = 1'b0; z_high_out = 1'b0;
      z_low_out = 1'b0; mdr_out = 1'b0; inport_out = 1'b0; c_out = 1'b0;
      read = 1'b0; write = 1'b0; alu_op = ALU_ADD; inc_pc = 1'b0;
      run = (state != S_HALTED);
      case (state)
         S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
         S_T1: begin z_low_out = 1'b1; pc_in = 1'b1; end
         S_T2: begin read = 1'b1; mdr_in = 1'b1; end
         S_T3: begin mdr_out = 1'b1; ir_in = 1'b1; end
         S_T4: begin
            case (inst_class)
               CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST: begin gpr_out = rb_oh; y_in = 1'b1; end
               CLS_MFHI: begin hi_out = 1'b1; gpr_in = ra_oh; end
               CLS_MFLO: begin lo_out = 1'b1; gpr_in = ra_oh; end
`ifdef MULDIV_EN
               CLS_MULDIV: begin gpr_out = ra_oh; y_in = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T5: begin
            case (inst_class)
               CLS_ALU: begin gpr_out = rc_oh; alu_op = alu_sel; z_in = 1'b1; end
               CLS_ADDI, CLS_LD, CLS_ST: begin c_out = 1'b1; alu_op = ALU_ADD; z_in = 1'b1; end
`ifdef MULDIV_EN
               CLS_MULDIV: begin gpr_out = rb_oh; alu_op = alu_sel; z_in = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T6: begin
            case (inst_class)
               CLS_ALU, CLS_ADDI: begin z_low_out = 1'b1; gpr_in = ra_oh; end
               CLS_LD, CLS_ST:    begin z_low_out = 1'b1; mar_in = 1'b1; end
`ifdef MULDIV_EN
               CLS_MULDIV: begin z_low_out = 1'b1; lo_in = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T7: begin
            case (inst_class)
               CLS_ST: begin gpr_out = ra_oh; mdr_in = 1'b1; end
`ifdef MULDIV_EN
               CLS_MULDIV: begin z_high_out = 1'b1; hi_in = 1'b1; end
`endif
               default: ;
            endcase
         end
         S_T8: begin
            if (inst_class == CLS_LD) begin read = 1'b1; mdr_in = 1'b1; end
            else if (inst_class == CLS_ST) write = 1'b1;
         end
         S_T9: begin
            if (inst_class == CLS_LD) begin mdr_out = 1'b1; gpr_in = ra_oh; end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  clk  in  1  sole clock; all state changes on its rising edge
  reset  in  1  asynchronous, active-high; forces the reset state immediately
  ir  in  32  instruction register contents from the datapath
  stop  in  1  halt request, sampled at instruction boundary
  gpr_in  out  16  one-hot load enable for R0-R15
  gpr_out  out  16  one-hot bus drive select for R0-R15
  hi_in, lo_in, pc_in, ir_in, z_in, y_in, mar_in, mdr_in  out  1 each  register load enables
  hi_out, lo_out, pc_out, z_high_out, z_low_out, mdr_out, inport_out, c_out  out  1 each  bus drive selects
  read  out  1  MDR source is memory (1) or bus (0)
  write  out  1  RAM write enable
  alu_op  out  4  ALU operation code
  inc_pc  out  1  ALU A operand is constant 4 instead of Y
  run  out  1  high while executing; low when halted
REQ-002 Instruction fields SHALL be: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL be a registered or pure function of the state and the latched ir fields, with no combinational path from stop.
REQ-004 The fetch sequence SHALL be:
  - T0: pc_out, mar_in, inc_pc, alu_op=ADD, z_in.
  - T1: z_low_out, pc_in (RAM read-latency wait).
  - T2: read, mdr_in.
  - T3: mdr_out, ir_in.
  - T4: decode and the first execute step; ir is valid from T4 onward.
REQ-005 In every cycle, at most one bus drive select (gpr_out bits plus the eight *_out signals) SHALL be high, and at most one gpr_in bit SHALL be high.
REQ-006 add/sub/and/or (0x03-0x06) SHALL execute as:
  - T4: gpr_out[rb], y_in.
  - T5: gpr_out[rc], alu_op, z_in.
  - T6: z_low_out, gpr_in[ra].
  - Then T0; total 7 cycles.
REQ-007 addi (0x0C) SHALL follow REQ-006 with c_out in place of gpr_out[rc] at T5.
REQ-008 ld (0x00) SHALL execute as:
  - T4: gpr_out[rb], y_in.
  - T5: c_out, ADD, z_in.
  - T6: z_low_out, mar_in.
  - T7: wait.
  - T8: read, mdr_in.
  - T9: mdr_out, gpr_in[ra].
  - Total 10 cycles.
REQ-009 st (0x02) SHALL execute as:
  - T4-T6: as ld.
  - T7: gpr_out[ra], mdr_in, read=0.
  - T8: write.
  - Total 9 cycles; write SHALL be high for exactly one cycle.
REQ-010 mfhi (0x17) and mflo (0x18) SHALL execute as:
  - T4: hi_out or lo_out, gpr_in[ra].
  - Total 5 cycles.
REQ-011 nop (0x1A) and any undefined opcode SHALL assert no enables in T4 and return to T0.
REQ-012 halt (0x1B) SHALL enter HALTED: all enables low, run=0, held until reset.
REQ-013 stop SHALL be sampled only in the cycle before T0; if high, the FSM SHALL enter HALTED instead of T0, so an in-flight instruction always completes.
REQ-014 alu_op codes SHALL be ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5.

Reset
REQ-015 While reset is high, state SHALL be T0-pending (RESET) with every output 0 except run=1; reset mid-instruction SHALL abandon the instruction with no partial write.
REQ-016 The first rising clk edge after reset deasserts SHALL enter T0.

Configuration
REQ-017 With MULDIV_EN defined, mul (0x0F) and div (0x10) SHALL execute as:
  - T4: gpr_out[ra], y_in.
  - T5: gpr_out[rb], MUL or DIV, z_in.
  - T6: z_low_out, lo_in.
  - T7: z_high_out, hi_in.
  - Total 8 cycles.
REQ-018 Without MULDIV_EN, 0x0F and 0x10 SHALL behave as nop, and hi_in/lo_in SHALL be constant 0.

Structure
REQ-019 A shared package control_pkg SHALL hold the opcode constants, the alu_op constants, the field bit positions and the state enumeration.
REQ-020 The one sub-module SHALL be ctrl_decoder: combinational opcode-to-instruction-class mapping plus 4-to-16 register-index decoding.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Reset high for 3 cycles, then low: all enables 0 during reset; pc_out=mar_in=inc_pc=z_in=1 on the first cycle after.
  - ir=add R1,R2,R3 (0x18918000): gpr_out=0x0004 at T4, gpr_out=0x0008 and alu_op=0 at T5, gpr_in=0x0002 at T6; next T0 at cycle 7.
  - ir=st R5,0(R6): write high only at T8; gpr_out=0x0020 with mdr_in=1 and read=0 at T7.
  - stop raised during T5 of add: the instruction completes, then run=0 with all enables 0 from the next cycle onward.
  - ir opcode 0x1F: no enables asserted at T4; T0 follows one cycle later.
  - mul R2,R3 with MULDIV_EN: lo_in at T6, hi_in at T7; without the macro, no hi_in/lo_in pulse.
  - All scenarios: a checker asserts REQ-005 one-hot on every cycle.
